// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB3 UART completer: register offsets,
// STATUS bit positions, FSM state encoding and error-counter width.
// Optional build macro: UART_IRQ_EN (maps IER at offset 0xC, adds irq).
package apb_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Word offsets, taken from PADDR[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_ERRCNT = 2'd2;
    localparam logic [1:0] REG_IER    = 2'd3;

    // STATUS register bit positions
    localparam int unsigned STAT_RX_EMPTY = 0;
    localparam int unsigned STAT_TX_FULL  = 1;
    localparam int unsigned STAT_TIMEOUT  = 2;

    localparam int unsigned ERRCNT_W = 8;
    localparam int unsigned IER_W    = 3;

endpackage

// File: rtl/apb_uart_completer_if.sv
// APB3 bus bundle between the bus master and the UART completer.
interface apb_uart_completer_if #(
    parameter int unsigned ADDR_W = 32
) ();

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_uart_completer.sv
// APB3 completer mapping the UART core FIFO handshake onto a four-word
// register window (DATA, STATUS, ERRCNT, IER/unmapped). Blocked DATA
// accesses wait for the FIFO and fail with PSLVERR after TIMEOUT cycles.
// Optional build macro: UART_IRQ_EN (IER register at 0xC plus irq output).
module apb_uart_completer
    import apb_uart_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned DATA_W  = 8
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    apb_uart_completer_if.slave  apb,
    output logic                 rd_uart,
    output logic                 wr_uart,
    output logic [DATA_W-1:0]    w_data,
    input  logic [DATA_W-1:0]    r_data,
    input  logic                 tx_full,
    input  logic                 rx_empty
`ifdef UART_IRQ_EN
    ,
    output logic                 irq
`endif
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    state_t                state_q, state_n;
    logic [1:0]            off_q, off_n;
    logic                  hi_bad_q, hi_bad_n;
    logic                  write_q, write_n;
    logic [31:0]           pwdata_q, pwdata_n;
    logic [CNT_W-1:0]      cnt_q, cnt_n, cnt_inc;
    logic                  sticky_q, sticky_n;
    logic [ERRCNT_W-1:0]   errcnt_q, errcnt_n;

    logic [31:0]           prdata_n;
    logic                  pready_n, pslverr_n;
    logic                  rd_n, wr_n;
    logic [DATA_W-1:0]     wdat_n;
    logic [31:0]           status;
    logic                  blocked, err, finish;

`ifdef UART_IRQ_EN
    logic [IER_W-1:0]      ier_q, ier_n;
    logic                  irq_n;
`endif

    // Address bits below the word offset and the upper write-data bits are
    // don't-cares for this register map.
    logic unused_bits;
    assign unused_bits = &{1'b0, apb.PADDR[1:0], pwdata_q};

    // Next-state and next-output decode; every output is registered below
    always_comb begin
        state_n   = state_q;
        off_n     = off_q;
        hi_bad_n  = hi_bad_q;
        write_n   = write_q;
        pwdata_n  = pwdata_q;
        cnt_n     = cnt_q;
        cnt_inc   = cnt_q + CNT_W'(1);
        sticky_n  = sticky_q;
        errcnt_n  = errcnt_q;
        prdata_n  = '0;
        pready_n  = 1'b0;
        pslverr_n = 1'b0;
        rd_n      = 1'b0;
        wr_n      = 1'b0;
        wdat_n    = '0;
        blocked   = 1'b0;
        err       = 1'b0;
        finish    = 1'b0;
`ifdef UART_IRQ_EN
        ier_n     = ier_q;
        irq_n     = |(ier_q & {sticky_q, ~tx_full, ~rx_empty});
`endif
        status                = '0;
        status[STAT_RX_EMPTY] = rx_empty;
        status[STAT_TX_FULL]  = tx_full;
        status[STAT_TIMEOUT]  = sticky_q;

        unique case (state_q)
            ST_IDLE: begin
                if (apb.PSEL && !apb.PENABLE) begin
                    state_n  = ST_WAIT;
                    off_n    = apb.PADDR[3:2];
                    hi_bad_n = |apb.PADDR[ADDR_W-1:4];
                    write_n  = apb.PWRITE;
                    pwdata_n = apb.PWDATA;
                    cnt_n    = '0;
                end
            end
            ST_WAIT: begin
                if (!apb.PSEL) begin
                    state_n = ST_IDLE;
                end else if (hi_bad_q) begin
                    err = 1'b1;
                end else begin
                    unique case (off_q)
                        REG_DATA: begin
                            if (write_q) begin
                                if (!tx_full) begin
                                    wr_n   = 1'b1;
                                    wdat_n = pwdata_q[DATA_W-1:0];
                                    finish = 1'b1;
                                end else begin
                                    blocked = 1'b1;
                                end
                            end else if (!rx_empty) begin
                                rd_n     = 1'b1;
                                prdata_n = 32'(r_data);
                                finish   = 1'b1;
                            end else begin
                                blocked = 1'b1;
                            end
                        end
                        REG_STATUS: begin
                            finish = 1'b1;
                            if (!write_q) begin
                                prdata_n = status;
                                sticky_n = 1'b0;
                            end
                        end
                        REG_ERRCNT: begin
                            finish = 1'b1;
                            if (write_q) errcnt_n = '0;
                            else         prdata_n = 32'(errcnt_q);
                        end
                        default: begin
`ifdef UART_IRQ_EN
                            finish = 1'b1;
                            if (write_q) ier_n    = pwdata_q[IER_W-1:0];
                            else         prdata_n = 32'(ier_q);
`else
                            err = 1'b1;
`endif
                        end
                    endcase
                end

                // Blocked DATA access: count stalled cycles, give up at the limit
                if (blocked && TIMEOUT != 0) begin
                    if (cnt_inc == CNT_LIMIT) begin
                        err      = 1'b1;
                        sticky_n = 1'b1;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end

                if (err) begin
                    finish    = 1'b1;
                    pslverr_n = 1'b1;
                    prdata_n  = '0;
                    if (errcnt_q != '1) errcnt_n = errcnt_q + ERRCNT_W'(1);
                end

                if (finish) begin
                    state_n  = ST_DONE;
                    pready_n = 1'b1;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // State, latched request and registered outputs
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            off_q       <= '0;
            hi_bad_q    <= 1'b0;
            write_q     <= 1'b0;
            pwdata_q    <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            errcnt_q    <= '0;
            apb.PRDATA  <= '0;
            apb.PREADY  <= 1'b0;
            apb.PSLVERR <= 1'b0;
            rd_uart     <= 1'b0;
            wr_uart     <= 1'b0;
            w_data      <= '0;
`ifdef UART_IRQ_EN
            ier_q       <= '0;
            irq         <= 1'b0;
`endif
        end else begin
            state_q     <= state_n;
            off_q       <= off_n;
            hi_bad_q    <= hi_bad_n;
            write_q     <= write_n;
            pwdata_q    <= pwdata_n;
            cnt_q       <= cnt_n;
            sticky_q    <= sticky_n;
            errcnt_q    <= errcnt_n;
            apb.PRDATA  <= prdata_n;
            apb.PREADY  <= pready_n;
            apb.PSLVERR <= pslverr_n;
            rd_uart     <= rd_n;
            wr_uart     <= wr_n;
            w_data      <= wdat_n;
`ifdef UART_IRQ_EN
            ier_q       <= ier_n;
            irq         <= irq_n;
`endif
        end
    end

endmodule

// File: tb/tb_apb_uart_completer.sv
// Self-checking bench for apb_uart_completer: directed scenarios followed by
// randomized register accesses, checked against a transaction-level model
// of the register map, FIFO occupancy and wait/timeout latency.
`timescale 1ns/1ps
module tb_apb_uart_completer;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned DATA_W  = 8;
`ifdef UART_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic              PCLK;
    logic              PRESET;
    logic              rd_uart, wr_uart;
    logic [DATA_W-1:0] w_data, r_data;
    logic              tx_full, rx_empty;
`ifdef UART_IRQ_EN
    logic              irq;
`endif

    apb_uart_completer_if #(.ADDR_W(ADDR_W)) apb ();

    apb_uart_completer #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT),
        .DATA_W  (DATA_W)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .apb      (apb),
        .rd_uart  (rd_uart),
        .wr_uart  (wr_uart),
        .w_data   (w_data),
        .r_data   (r_data),
        .tx_full  (tx_full),
        .rx_empty (rx_empty)
`ifdef UART_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] rxq[$];
    logic [7:0] pend_byte;
    int         rd_seen = 0, wr_seen = 0, both_seen = 0;
    logic [7:0] last_w;
    int         m_errcnt = 0;
    bit         m_sticky = 1'b0;
    logic [2:0] m_ier = 3'b000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_rx();
        rx_empty = (rxq.size() == 0);
        r_data   = (rxq.size() == 0) ? 8'h00 : rxq[0];
    endtask

    // Advance to the next falling edge and act as the UART FIFOs
    task automatic tick();
        @(negedge PCLK);
        if (rd_uart && wr_uart) both_seen++;
        if (rd_uart) begin
            rd_seen++;
            if (rxq.size() > 0) rxq.delete(0);
        end
        if (wr_uart) begin
            wr_seen++;
            last_w = w_data;
        end
        drive_rx();
    endtask

    task automatic unblock(input bit wr);
        if (wr) tx_full = 1'b0;
        else begin
            rxq.push_back(pend_byte);
            drive_rx();
        end
    endtask

    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int release_at, output logic [31:0] rdata,
                        output logic err, output int cycles);
        rdata = 'x;
        err   = 1'bx;
        tick();
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = wr;
        apb.PADDR   = addr;
        apb.PWDATA  = wdata;
        tick();
        apb.PENABLE = 1'b1;
        cycles = 1;
        if (release_at == 1) unblock(wr);
        while (cycles < 100) begin
            tick();
            cycles++;
            if (apb.PREADY === 1'b1) begin
                rdata = apb.PRDATA;
                err   = apb.PSLVERR;
                break;
            end
            if (cycles == release_at) unblock(wr);
        end
    endtask

    // One APB access predicted from the register-map rules, then checked
    task automatic op(input string tag, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input int release_at);
        logic [31:0] rdata, exp_rdata;
        logic        err;
        int          cycles, exp_cyc, rd0, wr0;
        logic [1:0]  off;
        bit          mapped, is_data, blocked, timeout, exp_err;

        off     = addr[3:2];
        mapped  = (addr[31:4] == 28'd0) && (off != 2'd3 || IRQ_BUILD);
        is_data = mapped && (off == 2'd0);
        blocked = is_data && (wr ? tx_full : rx_empty);
        timeout = blocked && (release_at == 0 || release_at > int'(TIMEOUT));
        exp_err = !mapped || timeout;
        exp_cyc = timeout ? int'(TIMEOUT) + 1 : (blocked ? release_at + 1 : 2);

        exp_rdata = 32'd0;
        if (!wr && !exp_err) begin
            case (off)
                2'd0:    exp_rdata = {24'd0, (rxq.size() > 0) ? rxq[0] : pend_byte};
                2'd1:    exp_rdata = {29'd0, m_sticky, tx_full, rx_empty};
                2'd2:    exp_rdata = 32'(m_errcnt);
                default: exp_rdata = {29'd0, m_ier};
            endcase
        end

        rd0 = rd_seen;
        wr0 = wr_seen;
        xfer(wr, addr, wdata, release_at, rdata, err, cycles);

        check({tag, ":cycles"},  32'(cycles), 32'(exp_cyc));
        check({tag, ":pslverr"}, {31'd0, err}, {31'd0, exp_err});
        check({tag, ":prdata"},  rdata, exp_rdata);
        check({tag, ":rd_uart"}, 32'(rd_seen - rd0), (is_data && !wr && !exp_err) ? 32'd1 : 32'd0);
        check({tag, ":wr_uart"}, 32'(wr_seen - wr0), (is_data && wr && !exp_err) ? 32'd1 : 32'd0);
        if (is_data && wr && !exp_err)
            check({tag, ":w_data"}, {24'd0, last_w}, {24'd0, wdata[7:0]});

        if (mapped && off == 2'd1 && !wr) m_sticky = 1'b0;
        if (mapped && off == 2'd2 && wr)  m_errcnt = 0;
        if (IRQ_BUILD && mapped && off == 2'd3 && wr) m_ier = wdata[2:0];
        if (timeout) m_sticky = 1'b1;
        if (exp_err && m_errcnt < 255) m_errcnt++;
    endtask

    initial begin
        int rd0, ready_seen;
        bit wr;
        logic [31:0] addr;

        PRESET      = 1'b1;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = '0;
        apb.PWDATA  = '0;
        tx_full     = 1'b0;
        pend_byte   = 8'h00;
        last_w      = 8'h00;
        drive_rx();

        // Reset values
        repeat (3) tick();
        check("rst:PREADY",  {31'd0, apb.PREADY},  32'd0);
        check("rst:PSLVERR", {31'd0, apb.PSLVERR}, 32'd0);
        check("rst:PRDATA",  apb.PRDATA, 32'd0);
        check("rst:rd_uart", {31'd0, rd_uart}, 32'd0);
        check("rst:wr_uart", {31'd0, wr_uart}, 32'd0);
        check("rst:w_data",  {24'd0, w_data},  32'd0);
        PRESET = 1'b0;
        tick();

        // Directed: plain write, plain read, timed-out read, status and count
        op("wr5A", 1'b1, 32'h0, 32'h0000_005A, 0);
        rxq.push_back(8'hC3);
        drive_rx();
        op("rdC3", 1'b0, 32'h0, 32'h0, 0);
        op("rd_timeout", 1'b0, 32'h0, 32'h0, 0);
        op("status_after_to", 1'b0, 32'h4, 32'h0, 0);
        op("errcnt_after_to", 1'b0, 32'h8, 32'h0, 0);
        op("status_cleared", 1'b0, 32'h4, 32'h0, 0);

        // Directed: write held off by a full TX FIFO for three cycles
        tx_full = 1'b1;
        op("wr_txfull3", 1'b1, 32'h0, 32'h0000_00A7, 3);

        // Directed: unmapped addresses and writes that must be harmless
        op("unmapped10", 1'b0, 32'h10, 32'h0, 0);
        op("unmappedC",  1'b1, 32'hC, 32'h7, 0);
        op("status_wr",  1'b1, 32'h4, 32'hFFFF_FFFF, 0);

        // Randomized accesses
        for (int i = 0; i < 150; i++) begin
            wr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0, 1:    addr = 32'h0;
                2:       addr = 32'h4;
                3:       addr = 32'h8;
                4:       addr = 32'hC;
                default: addr = 32'($urandom_range(1, 4095)) << 4;
            endcase
            addr      = addr | 32'($urandom_range(0, 3));
            tx_full   = ($urandom_range(0, 2) == 0);
            pend_byte = 8'($urandom);
            if ($urandom_range(0, 2) == 0) rxq.delete();
            else if (rxq.size() < 3) rxq.push_back(8'($urandom));
            drive_rx();
            op("rand", wr, addr, $urandom, $urandom_range(0, 20));
        end

        // PSEL dropped during a blocked read: no pop, no PREADY, FSM recovers
        rxq.delete();
        tx_full = 1'b0;
        drive_rx();
        tick();
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = 32'h0;
        tick();
        apb.PENABLE = 1'b1;
        tick();
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        rxq.push_back(8'h3C);
        drive_rx();
        rd0 = rd_seen;
        ready_seen = 0;
        repeat (4) begin
            tick();
            if (apb.PREADY === 1'b1) ready_seen++;
        end
        check("psel_drop:rd_uart", 32'(rd_seen - rd0), 32'd0);
        check("psel_drop:PREADY",  32'(ready_seen), 32'd0);
        op("after_drop_rd", 1'b0, 32'h0, 32'h0, 0);

        // Error counter saturation and clear
        for (int i = 0; i < 300; i++)
            op("sat", 1'(i & 1), 32'h10, 32'h0, 0);
        op("errcnt_sat", 1'b0, 32'h8, 32'h0, 0);
        op("errcnt_clr", 1'b1, 32'h8, 32'h0, 0);
        op("errcnt_zero", 1'b0, 32'h8, 32'h0, 0);
        op("unmapped_again", 1'b0, 32'h10, 32'h0, 0);

        // Reset in the middle of a blocked read
        rxq.delete();
        drive_rx();
        tick();
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = 32'h0;
        tick();
        apb.PENABLE = 1'b1;
        repeat (3) tick();
        PRESET = 1'b1;
        tick();
        check("midrst:PREADY",  {31'd0, apb.PREADY},  32'd0);
        check("midrst:PSLVERR", {31'd0, apb.PSLVERR}, 32'd0);
        check("midrst:PRDATA",  apb.PRDATA, 32'd0);
        check("midrst:rd_uart", {31'd0, rd_uart}, 32'd0);
        check("midrst:wr_uart", {31'd0, wr_uart}, 32'd0);
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        PRESET   = 1'b0;
        m_errcnt = 0;
        m_sticky = 1'b0;
        m_ier    = 3'b000;
        rxq.push_back(8'h99);
        drive_rx();
        rd0 = rd_seen;
        repeat (3) tick();
        check("midrst:dropped", 32'(rd_seen - rd0), 32'd0);
        op("midrst_status", 1'b0, 32'h4, 32'h0, 0);
        op("midrst_errcnt", 1'b0, 32'h8, 32'h0, 0);
        op("midrst_rd", 1'b0, 32'h0, 32'h0, 0);

        check("strobe_exclusive", 32'(both_seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
